// File: rtl/stopwatch_ctrl.sv
// Front-panel controller for the hh:mm:ss:xx stopwatch/countdown counter.
// Conditions four raw keys and turns them into one-cycle counter pulses, run state and a buzzer.
module stopwatch_ctrl #(
   parameter int DEBOUNCE_TICKS = 2,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_RATE    = 10,
   parameter int BEEP_TICKS     = 200
) (
   input  logic clk_100Hz,
   input  logic rst_n,
   input  logic key_ss,
   input  logic key_mode,
   input  logic key_sel,
   input  logic key_inc,
   input  logic time_zero,
   output logic start,
   output logic stop,
   output logic min_inc,
   output logic hour_inc,
   output logic countdown_mode,
   output logic sel_hour,
   output logic running,
   output logic buzzer
);

   localparam int K_SS   = 0;
   localparam int K_MODE = 1;
   localparam int K_SEL  = 2;
   localparam int K_INC  = 3;

   localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_TICKS - 1);
   localparam logic [7:0] RPT_DELAY = 8'(REPEAT_DELAY);
   localparam logic [7:0] RPT_RATE  = 8'(REPEAT_RATE);
   localparam logic [7:0] BEEP_LOAD = 8'(BEEP_TICKS);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

   logic [3:0] raw, sync_a, sync_b, deb, deb_d, armed, press;
   logic [7:0] db_cnt [4];
   logic [1:0] settle;

   assign raw   = {key_inc, key_sel, key_mode, key_ss};
   assign press = deb & ~deb_d & armed;

   // A key held through reset must be seen released once before it can produce a press.
   always_ff @(posedge clk_100Hz or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         deb    <= '0;
         deb_d  <= '0;
         armed  <= '0;
         settle <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, so sync_a -> sync_b is a real two-stage chain.
         sync_a <= raw;
         sync_b <= sync_a;
         deb_d  <= deb;
         settle <= {settle[0], 1'b1};
         for (int i = 0; i < 4; i++) begin
            if (sync_b[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] >= DB_LAST) begin
               deb[i]    <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
            if (settle[1] && !sync_b[i]) armed[i] <= 1'b1;
         end
      end
   end

   state_t     state, state_n;
   logic       tz_q;
   logic [7:0] beep_cnt, beep_n;
   logic [7:0] rpt_cnt, rpt_cnt_n;
   logic       rpt_slow, rpt_slow_n, rpt_armed, rpt_armed_n;
   logic       start_n, stop_n, min_n, hour_n, mode_n, sel_n;
   logic       rpt_fire, inc_fire;

   always_ff @(posedge clk_100Hz or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         tz_q           <= 1'b0;
         beep_cnt       <= '0;
         rpt_cnt        <= '0;
         rpt_slow       <= 1'b0;
         rpt_armed      <= 1'b0;
         start          <= 1'b0;
         stop           <= 1'b0;
         min_inc        <= 1'b0;
         hour_inc       <= 1'b0;
         countdown_mode <= 1'b0;
         sel_hour       <= 1'b0;
      end else begin
         state          <= state_n;
         tz_q           <= time_zero;
         beep_cnt       <= beep_n;
         rpt_cnt        <= rpt_cnt_n;
         rpt_slow       <= rpt_slow_n;
         rpt_armed      <= rpt_armed_n;
         start          <= start_n;
         stop           <= stop_n;
         min_inc        <= min_n;
         hour_inc       <= hour_n;
         countdown_mode <= mode_n;
         sel_hour       <= sel_n;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that leaves one unassigned would infer a latch.
      state_n     = state;
      start_n     = 1'b0;
      stop_n      = 1'b0;
      min_n       = 1'b0;
      hour_n      = 1'b0;
      mode_n      = countdown_mode;
      sel_n       = sel_hour;
      beep_n      = beep_cnt;
      rpt_cnt_n   = rpt_cnt;
      rpt_slow_n  = rpt_slow;
      rpt_armed_n = rpt_armed;
      inc_fire    = 1'b0;
      rpt_fire    = rpt_armed && deb[K_INC] && (rpt_cnt == (rpt_slow ? RPT_RATE : RPT_DELAY));

      // One key event per cycle, highest priority wins; a repeat tick ranks with key_inc.
      case (state)
         IDLE, PAUSE: begin
            if (press[K_SS]) begin
               if (!(countdown_mode && tz_q)) begin
                  state_n = RUN;
                  start_n = 1'b1;
               end
            end else if (press[K_MODE]) begin
               mode_n  = !countdown_mode;
               sel_n   = 1'b0;
               state_n = IDLE;
            end else if (press[K_SEL]) begin
               if (countdown_mode) sel_n = !sel_hour;
            end else if (press[K_INC] || rpt_fire) begin
               inc_fire = countdown_mode;
            end
         end
         RUN: begin
            if (countdown_mode && tz_q) begin
               state_n = ALARM;
               beep_n  = BEEP_LOAD;
            end else if (press[K_SS]) begin
               state_n = PAUSE;
               stop_n  = 1'b1;
            end
         end
         ALARM: begin
            if (beep_cnt <= 8'd1 || press != 4'b0000) state_n = PAUSE;
            else                                      beep_n  = beep_cnt - 8'd1;
         end
         default: state_n = IDLE;
      endcase

      if (inc_fire) begin
         min_n       = !sel_hour;
         hour_n      = sel_hour;
         rpt_armed_n = 1'b1;
         rpt_cnt_n   = 8'd1;
         rpt_slow_n  = !press[K_INC];
      end else if (rpt_armed && rpt_cnt != 8'hFF) begin
         rpt_cnt_n = rpt_cnt + 8'd1;
      end

      if (!deb[K_INC] || !mode_n || (sel_n != sel_hour) || !(state_n == IDLE || state_n == PAUSE)) begin
         rpt_armed_n = 1'b0;
         rpt_cnt_n   = '0;
         rpt_slow_n  = 1'b0;
      end
   end

   always_comb begin
      running = (state == RUN);
      buzzer  = (state == ALARM);
   end

endmodule
